// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with memory handshake.
// Optional performance counters are enabled by defining SEQ_PERF_CNT_EN.
module multicycle_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] opCode,
  input  logic       funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IrWrite,
  output logic       PcWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MemLoad,
  output logic [2:0] state,
  output logic       halted
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0] cycle_cnt,
  output logic [15:0] retire_cnt
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t state_reg;

  logic is_lw;
  logic is_sw;
  logic is_jump;
  logic is_halt;

  assign is_lw   = (opCode == 3'b010);
  assign is_sw   = (opCode == 3'b011);
  assign is_jump = (opCode == 3'b100) || ((opCode == 3'b111) && !funct);
  assign is_halt = (opCode == 3'b111) && funct;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      case (state_reg)
        FETCH:  if (mem_ready) state_reg <= DECODE;
        DECODE: state_reg <= is_halt ? HALT : EXEC;
        EXEC: begin
          if (is_lw || is_sw)
            state_reg <= MEM;
          else if (opCode == 3'b100 || opCode == 3'b111)
            state_reg <= FETCH;
          else
            state_reg <= WB;
        end
        MEM:    if (mem_ready) state_reg <= is_lw ? WB : FETCH;
        WB:     state_reg <= FETCH;
        HALT:   state_reg <= HALT;
        default: state_reg <= FETCH;
      endcase
    end
  end

  // Strobes decode the registered state; mem_ready is the only combinational
  // input besides the held instruction fields. Reset suppresses every strobe.
  always_comb begin
    mem_req  = (state_reg == FETCH) || (state_reg == MEM);
    IrWrite  = 1'b0;
    PcWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    MemLoad  = 1'b0;
    if (!reset) begin
      case (state_reg)
        FETCH: IrWrite = mem_ready;
        EXEC:  PcWrite = is_jump;
        MEM: begin
          MemLoad  = is_lw;
          MemWrite = mem_ready && is_sw;
          PcWrite  = mem_ready && is_sw;
        end
        WB: begin
          RegWrite = 1'b1;
          PcWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state  = state_reg;
  assign halted = (state_reg == HALT);

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cycle_cnt_reg;
  logic [15:0] retire_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt_reg  <= 16'd0;
      retire_cnt_reg <= 16'd0;
    end else begin
      if (state_reg != HALT)
        cycle_cnt_reg <= cycle_cnt_reg + 16'd1;
      // Entering HALT retires the halt instruction even though the PC is not written.
      if (PcWrite || ((state_reg == DECODE) && is_halt))
        retire_cnt_reg <= retire_cnt_reg + 16'd1;
    end
  end

  assign cycle_cnt  = cycle_cnt_reg;
  assign retire_cnt = retire_cnt_reg;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed, table-driven bench for multicycle_sequencer; each vector is one clock cycle.
module tb_multicycle_sequencer;

  logic       clock;
  logic       reset;
  logic [2:0] opCode;
  logic       funct;
  logic       mem_ready;
  logic       mem_req;
  logic       IrWrite;
  logic       PcWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       MemLoad;
  logic [2:0] state;
  logic       halted;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cycle_cnt;
  logic [15:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .opCode    (opCode),
    .funct     (funct),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .IrWrite   (IrWrite),
    .PcWrite   (PcWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .MemLoad   (MemLoad),
    .state     (state),
    .halted    (halted)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cycle_cnt (cycle_cnt),
    .retire_cnt(retire_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected output bits: {mem_req, IrWrite, PcWrite, RegWrite, MemWrite, MemLoad, halted}
  typedef struct {
    logic       r;
    logic [2:0] op;
    logic       fn;
    logic       rdy;
    logic [2:0] st;
    logic [6:0] o;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [2:0] op, input logic fn,
                              input logic rdy, input logic [2:0] st, input logic [6:0] o);
    vec_t v;
    v.r = r; v.op = op; v.fn = fn; v.rdy = rdy; v.st = st; v.o = o;
    return v;
  endfunction

  // Drive one cycle's inputs after the falling edge, then compare before the next rising edge.
  task automatic step(input logic r, input logic [2:0] op, input logic fn, input logic rdy,
                      input logic [2:0] es, input logic [6:0] eo, input string tag);
    logic [9:0] got;
    logic [9:0] exp;
    @(negedge clock);
    reset = r; opCode = op; funct = fn; mem_ready = rdy;
    #1;
    got = {state, mem_req, IrWrite, PcWrite, RegWrite, MemWrite, MemLoad, halted};
    exp = {es, eo};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d out=%b, expected state=%0d out=%b",
               tag, got[9:7], got[6:0], exp[9:7], exp[6:0]);
    end else begin
      $display("ok   %s: state=%0d out=%b", tag, got[9:7], got[6:0]);
    end
  endtask

  initial begin
    reset = 1'b1; opCode = 3'b000; funct = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clock);

    // reset state: strobes suppressed, mem_req up in FETCH
    vecs.push_back(mk(1, 3'b000, 0, 1, 3'd0, 7'b1000000));
    // ALU op 000: 0,1,2,4,0
    vecs.push_back(mk(0, 3'b000, 0, 1, 3'd0, 7'b1100000));
    vecs.push_back(mk(0, 3'b000, 0, 1, 3'd1, 7'b0000000));
    vecs.push_back(mk(0, 3'b000, 0, 1, 3'd2, 7'b0000000));
    vecs.push_back(mk(0, 3'b000, 0, 1, 3'd4, 7'b0011000));
    // lw with a fetch stall and three MEM wait cycles
    vecs.push_back(mk(0, 3'b010, 0, 0, 3'd0, 7'b1000000));
    vecs.push_back(mk(0, 3'b010, 0, 1, 3'd0, 7'b1100000));
    vecs.push_back(mk(0, 3'b010, 0, 0, 3'd1, 7'b0000000));
    vecs.push_back(mk(0, 3'b010, 0, 0, 3'd2, 7'b0000000));
    vecs.push_back(mk(0, 3'b010, 0, 0, 3'd3, 7'b1000010));
    vecs.push_back(mk(0, 3'b010, 0, 0, 3'd3, 7'b1000010));
    vecs.push_back(mk(0, 3'b010, 0, 0, 3'd3, 7'b1000010));
    vecs.push_back(mk(0, 3'b010, 0, 1, 3'd3, 7'b1000010));
    vecs.push_back(mk(0, 3'b010, 0, 1, 3'd4, 7'b0011000));
    // sw, mem_ready=1: MemWrite+PcWrite together, no RegWrite
    vecs.push_back(mk(0, 3'b011, 0, 1, 3'd0, 7'b1100000));
    vecs.push_back(mk(0, 3'b011, 0, 1, 3'd1, 7'b0000000));
    vecs.push_back(mk(0, 3'b011, 0, 1, 3'd2, 7'b0000000));
    vecs.push_back(mk(0, 3'b011, 0, 1, 3'd3, 7'b1010100));
    // bnez: 3 cycles
    vecs.push_back(mk(0, 3'b100, 0, 1, 3'd0, 7'b1100000));
    vecs.push_back(mk(0, 3'b100, 0, 1, 3'd1, 7'b0000000));
    vecs.push_back(mk(0, 3'b100, 0, 1, 3'd2, 7'b0010000));
    // jr: 3 cycles
    vecs.push_back(mk(0, 3'b111, 0, 1, 3'd0, 7'b1100000));
    vecs.push_back(mk(0, 3'b111, 0, 1, 3'd1, 7'b0000000));
    vecs.push_back(mk(0, 3'b111, 0, 1, 3'd2, 7'b0010000));
    // set op 101 with a fetch stall
    vecs.push_back(mk(0, 3'b101, 0, 0, 3'd0, 7'b1000000));
    vecs.push_back(mk(0, 3'b101, 0, 1, 3'd0, 7'b1100000));
    vecs.push_back(mk(0, 3'b101, 0, 1, 3'd1, 7'b0000000));
    vecs.push_back(mk(0, 3'b101, 0, 1, 3'd2, 7'b0000000));
    vecs.push_back(mk(0, 3'b101, 0, 1, 3'd4, 7'b0011000));
    // sw interrupted by reset on its mem_ready cycle
    vecs.push_back(mk(0, 3'b011, 0, 1, 3'd0, 7'b1100000));
    vecs.push_back(mk(0, 3'b011, 0, 1, 3'd1, 7'b0000000));
    vecs.push_back(mk(0, 3'b011, 0, 1, 3'd2, 7'b0000000));
    vecs.push_back(mk(0, 3'b011, 0, 0, 3'd3, 7'b1000000));
    vecs.push_back(mk(1, 3'b011, 0, 1, 3'd3, 7'b1000000));
    vecs.push_back(mk(0, 3'b011, 0, 0, 3'd0, 7'b1000000));

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].r, vecs[i].op, vecs[i].fn, vecs[i].rdy, vecs[i].st, vecs[i].o,
           $sformatf("vec%0d", i));

    // halt: HALT two cycles after FETCH, sticky against any inputs, left only by reset
    step(0, 3'b111, 1, 1, 3'd0, 7'b1100000, "halt_fetch");
    step(0, 3'b111, 1, 1, 3'd1, 7'b0000000, "halt_decode");
    for (int i = 0; i < 20; i++)
      step(0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'd5, 7'b0000001, $sformatf("halt_hold%0d", i));
    step(1, 3'b000, 0, 1, 3'd5, 7'b0000001, "halt_reset");
    step(0, 3'b000, 0, 0, 3'd0, 7'b1000000, "after_halt_reset");

`ifdef SEQ_PERF_CNT_EN
    step(1, 3'b000, 0, 1, 3'd0, 7'b1000000, "perf_reset");
    for (int k = 0; k < 10; k++) begin
      step(0, 3'b000, 0, 1, 3'd0, 7'b1100000, $sformatf("perf%0d_f", k));
      step(0, 3'b000, 0, 1, 3'd1, 7'b0000000, $sformatf("perf%0d_d", k));
      step(0, 3'b000, 0, 1, 3'd2, 7'b0000000, $sformatf("perf%0d_e", k));
      step(0, 3'b000, 0, 1, 3'd4, 7'b0011000, $sformatf("perf%0d_w", k));
    end
    @(negedge clock);
    #1;
    checks++;
    if (cycle_cnt !== 16'd40 || retire_cnt !== 16'd10) begin
      errors++;
      $display("FAIL perf_counts: got cycle=%0d retire=%0d, expected cycle=40 retire=10",
               cycle_cnt, retire_cnt);
    end else begin
      $display("ok   perf_counts: cycle=%0d retire=%0d", cycle_cnt, retire_cnt);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
